evo_xb_pin_irq: RTL and testbench
=================================

Name: evo_xb_pin_irq

Overview:
- Per-pin edge-detect interrupt controller living inside evo_xb.
- Consumes a port pmux input bus (port_e_pmux_in by default) and produces the xb_int request consumed by the BSP interrupt logic.
- Register access is through the XB Avalon-MM CSR slave bus. eic_swrst from the BSP clears all of its state.
- Optional glitch filter per pin, sampled on en1mhz.

Parameters:
- NPINS, 32, number of monitored pins (1..32)
- AWIDTH, 3, CSR word-address width
- DWIDTH, 32, CSR data width

Ports:
- clk  input  1  CSR/logic clock (clk_bsp)
- reset_n  input  1  asynchronous active-low reset
- en1mhz  input  1  single-cycle 1 MHz enable pulse, filter sample strobe
- pins_i  input  NPINS  raw pad inputs from pmux (asynchronous)
- eic_swrst_i  input  1  synchronous soft reset, active-high
- xb_int_o  output  1  interrupt request, registered, level
- avs_csr_address  input  AWIDTH  word address
- avs_csr_read  input  1  read strobe
- avs_csr_write  input  1  write strobe
- avs_csr_writedata  input  DWIDTH  write data
- avs_csr_readdata  output  DWIDTH  read data
- avs_csr_readdatavalid  output  1  read data valid
- avs_csr_waitrequest  output  1  tied 0

Behaviour:
- Async reset: all registers, xb_int_o, readdata and readdatavalid go to 0.
- Input path: 2-FF synchronizer (s1, s2) per pin, followed by a filter stage producing filt.
- FILT_EN bit = 0: filt <= s2 every clk.
- FILT_EN bit = 1: per-pin 3-deep shift register sampled on en1mhz. filt updates only when all 3 samples are equal, otherwise it holds.
- Edge detect: prev <= filt every clk. rise = filt & ~prev; fall = ~filt & prev.
- FLAG[i] set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Latency, filter off: pad change captured at edge 1 gives s2 at edge 2, filt at edge 3, FLAG at edge 4, xb_int_o at edge 5.
- xb_int_o <= |(FLAG & IRQ_EN), registered.
- Register map (word addresses); bits above NPINS read 0 and ignore writes:
  - 0 IN  RO: filt
  - 1 RISE_EN  RW
  - 2 FALL_EN  RW
  - 3 FLAG  R/W1C
  - 4 IRQ_EN  RW
  - 5 CTRL  RW: bit0 FILT_EN
  - 6 RAW  RO: s2
  - 7 reads 0, writes ignored
- Reads: fixed latency 1. readdatavalid pulses high exactly one cycle after avs_csr_read with readdata valid in that cycle. readdata holds its value otherwise. Back-to-back reads give back-to-back valids.
- Read and write in the same cycle: the write commits; the read returns the pre-write value.
- FLAG W1C coinciding with a new set on the same bit: set wins, bit stays 1.
- Disabling RISE_EN/FALL_EN does not clear existing FLAG bits. Clearing IRQ_EN deasserts xb_int_o one cycle later.
- Both RISE_EN and FALL_EN set: every toggle flags.
- eic_swrst_i = 1 on a clock: clears RISE_EN, FALL_EN, FLAG, IRQ_EN, CTRL and xb_int_o next edge. Synchronizer, filter and prev continue running, so no spurious edge is created. swrst has priority over CSR writes in the same cycle.
- Filter toggled mid-operation: the shift register keeps sampling regardless of FILT_EN, so switching mode only changes the filt source on the next clk.
- Async reset mid-read: the pending readdatavalid is dropped.

Test Plan:
- Reset, then read all 8 addresses -> each readdatavalid one cycle after its read, all data 0, xb_int_o 0.
- RISE_EN=0x1, IRQ_EN=0x1, pins_i[0] 0->1 (filter off) -> FLAG=0x1 at edge 4 and xb_int_o=1 at edge 5.
- Then write FLAG=0x1 -> xb_int_o=0 two cycles later.
- FALL_EN=0x80000000, pin31 1->0 -> FLAG=0x80000000. A W1C write of 0x80000000 in the same cycle as a second falling edge leaves FLAG=0x80000000.
- FILT_EN=1, RISE_EN=0x2, 1-clk glitch on pin1 between en1mhz pulses -> FLAG stays 0. Pin1 held high for 3 en1mhz samples -> IN bit1=1 and FLAG=0x2.
- Flags pending and xb_int_o=1, pulse eic_swrst_i coincident with a write of IRQ_EN=0xFFFF -> next cycle IRQ_EN=0, FLAG=0, xb_int_o=0, and no new flag while pins hold steady.
- Read IRQ_EN and write IRQ_EN=0x5 in the same cycle -> readdata shows the old value; a following read returns 0x5.

Source files
------------

// File: rtl/evo_xb_pin_irq.sv
// Per-pin edge-detect interrupt controller for evo_xb: a synchronizer and an optional glitch
// filter per pin, rise/fall enables, sticky W1C flags and a registered interrupt request.
module evo_xb_pin_irq #(
    parameter int unsigned NPINS  = 32,
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en1mhz,
    input  logic [NPINS-1:0]  pins_i,
    input  logic              eic_swrst_i,
    output logic              xb_int_o,
    input  logic [AWIDTH-1:0] avs_csr_address,
    input  logic              avs_csr_read,
    input  logic              avs_csr_write,
    input  logic [DWIDTH-1:0] avs_csr_writedata,
    output logic [DWIDTH-1:0] avs_csr_readdata,
    output logic              avs_csr_readdatavalid,
    output logic              avs_csr_waitrequest
);

    localparam logic [AWIDTH-1:0] AddrIn     = AWIDTH'(0);
    localparam logic [AWIDTH-1:0] AddrRiseEn = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] AddrFallEn = AWIDTH'(2);
    localparam logic [AWIDTH-1:0] AddrFlag   = AWIDTH'(3);
    localparam logic [AWIDTH-1:0] AddrIrqEn  = AWIDTH'(4);
    localparam logic [AWIDTH-1:0] AddrCtrl   = AWIDTH'(5);
    localparam logic [AWIDTH-1:0] AddrRaw    = AWIDTH'(6);

    logic [NPINS-1:0] s1_q, s2_q;
    logic [NPINS-1:0] sh0_q, sh1_q, sh2_q;
    logic [NPINS-1:0] filt_q, filt_d, prev_q;
    logic [NPINS-1:0] all_eq, rise, fall, flag_set;
    logic [NPINS-1:0] rise_en_q, fall_en_q, flag_q, flag_d, irq_en_q;
    logic [NPINS-1:0] wdata, w1c_mask;
    logic             filt_en_q;
    logic             xb_int_q;
    logic             wr_rise, wr_fall, wr_flag, wr_irq, wr_ctrl;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q;

    assign avs_csr_waitrequest   = 1'b0;
    assign avs_csr_readdata      = rdata_q;
    assign avs_csr_readdatavalid = rvalid_q;
    assign xb_int_o              = xb_int_q;

    // Input path is never touched by the soft reset so prev/filt stay coherent with the pads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            sh0_q  <= '0;
            sh1_q  <= '0;
            sh2_q  <= '0;
            filt_q <= '0;
            prev_q <= '0;
        end else begin
            s1_q <= pins_i;
            s2_q <= s1_q;
            if (en1mhz) begin
                sh0_q <= s2_q;
                sh1_q <= sh0_q;
                sh2_q <= sh1_q;
            end
            filt_q <= filt_d;
            prev_q <= filt_q;
        end
    end

    always_comb begin
        all_eq = ~(sh0_q ^ sh1_q) & ~(sh1_q ^ sh2_q);
        filt_d = filt_en_q ? ((all_eq & sh0_q) | (~all_eq & filt_q)) : s2_q;
    end

    always_comb begin
        wdata    = avs_csr_writedata[NPINS-1:0];
        wr_rise  = avs_csr_write && (avs_csr_address == AddrRiseEn);
        wr_fall  = avs_csr_write && (avs_csr_address == AddrFallEn);
        wr_flag  = avs_csr_write && (avs_csr_address == AddrFlag);
        wr_irq   = avs_csr_write && (avs_csr_address == AddrIrqEn);
        wr_ctrl  = avs_csr_write && (avs_csr_address == AddrCtrl);
        rise     = filt_q & ~prev_q;
        fall     = ~filt_q & prev_q;
        flag_set = (rise & rise_en_q) | (fall & fall_en_q);
        w1c_mask = wr_flag ? wdata : '0;
        // A new edge on the same cycle as its W1C keeps the bit set.
        flag_d   = (flag_q & ~w1c_mask) | flag_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            flag_q    <= '0;
            irq_en_q  <= '0;
            filt_en_q <= 1'b0;
            xb_int_q  <= 1'b0;
        end else if (eic_swrst_i) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            flag_q    <= '0;
            irq_en_q  <= '0;
            filt_en_q <= 1'b0;
            xb_int_q  <= 1'b0;
        end else begin
            if (wr_rise) rise_en_q <= wdata;
            if (wr_fall) fall_en_q <= wdata;
            if (wr_irq)  irq_en_q  <= wdata;
            if (wr_ctrl) filt_en_q <= avs_csr_writedata[0];
            flag_q   <= flag_d;
            xb_int_q <= |(flag_q & irq_en_q);
        end
    end

    // Readback samples current (pre-write) state; data holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_csr_read) begin
            rdata_d = '0;
            case (avs_csr_address)
                AddrIn:     rdata_d[NPINS-1:0] = filt_q;
                AddrRiseEn: rdata_d[NPINS-1:0] = rise_en_q;
                AddrFallEn: rdata_d[NPINS-1:0] = fall_en_q;
                AddrFlag:   rdata_d[NPINS-1:0] = flag_q;
                AddrIrqEn:  rdata_d[NPINS-1:0] = irq_en_q;
                AddrCtrl:   rdata_d[0]         = filt_en_q;
                AddrRaw:    rdata_d[NPINS-1:0] = s2_q;
                default:    rdata_d            = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= avs_csr_read;
        end
    end

endmodule

// File: tb/tb_evo_xb_pin_irq.sv
// Self-checking bench for evo_xb_pin_irq: directed scenarios plus a randomized pin-toggle run
// compared against an edge/flag model derived from the register semantics.
module tb_evo_xb_pin_irq;

    localparam int A_IN = 0, A_RISE = 1, A_FALL = 2, A_FLAG = 3;
    localparam int A_IRQ = 4, A_CTRL = 5, A_RAW = 6, A_NONE = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en1mhz = 1'b0;
    logic [31:0] pins = '0;
    logic        eic_swrst = 1'b0;
    logic        xb_int;
    logic [2:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        waitreq;

    int n_cmp = 0;
    int n_err = 0;

    evo_xb_pin_irq #(.NPINS(32), .AWIDTH(3), .DWIDTH(32)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .en1mhz                (en1mhz),
        .pins_i                (pins),
        .eic_swrst_i           (eic_swrst),
        .xb_int_o              (xb_int),
        .avs_csr_address       (addr),
        .avs_csr_read          (rd),
        .avs_csr_write         (wr),
        .avs_csr_writedata     (wdata),
        .avs_csr_readdata      (rdata),
        .avs_csr_readdatavalid (rvalid),
        .avs_csr_waitrequest   (waitreq)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (9) @(posedge clk);
            #1 en1mhz = 1'b1;
            @(posedge clk);
            #1 en1mhz = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input int a, input logic [31:0] d);
        addr = 3'(a);
        wdata = d;
        wr = 1'b1;
        step(1);
        wr = 1'b0;
    endtask

    task automatic csr_rd(input int a, output logic [31:0] d, output logic v);
        addr = 3'(a);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic v;
        step(3);
        n_cmp++;
        if ({xb_int, rvalid, rdata, waitreq} !== 35'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got int=%b valid=%b data=%h wait=%b required all 0",
                     xb_int, rvalid, rdata, waitreq);
        end
        reset_n = 1'b1;
        step(1);
        for (int a = 0; a < 8; a++) begin
            csr_rd(a, d, v);
            n_cmp++;
            if (v !== 1'b1 || d !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read addr %0d: got valid=%b data=%h required 1/00000000",
                         a, v, d);
            end
        end
        step(1);
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_drop: got %b required 0", rvalid);
        end
    endtask

    task automatic test_rise_latency();
        logic [31:0] d;
        logic v;
        csr_wr(A_RISE, 32'h1);
        csr_wr(A_IRQ, 32'h1);
        step(6);
        pins[0] = 1'b1;
        step(3);
        csr_rd(A_FLAG, d, v);  // sampled at edge 4: still the old flag
        n_cmp++;
        if (d !== 32'h0 || xb_int !== 1'b0) begin
            n_err++;
            $display("FAIL rise_edge4: got flag=%h int=%b required 00000000/0", d, xb_int);
        end
        csr_rd(A_FLAG, d, v);
        n_cmp++;
        if (d !== 32'h1 || xb_int !== 1'b1) begin
            n_err++;
            $display("FAIL rise_edge5: got flag=%h int=%b required 00000001/1", d, xb_int);
        end
        csr_wr(A_FLAG, 32'h1);
        n_cmp++;
        if (xb_int !== 1'b1) begin
            n_err++;
            $display("FAIL w1c_int_hold: got %b required 1", xb_int);
        end
        step(1);
        n_cmp++;
        if (xb_int !== 1'b0) begin
            n_err++;
            $display("FAIL w1c_int_clear: got %b required 0", xb_int);
        end
        csr_rd(A_FLAG, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL w1c_flag: got %h required 00000000", d);
        end
    endtask

    task automatic test_fall_w1c();
        logic [31:0] d;
        logic v;
        csr_wr(A_FALL, 32'h8000_0000);
        pins[31] = 1'b1;
        step(8);
        pins[31] = 1'b0;
        step(8);
        csr_rd(A_FLAG, d, v);
        n_cmp++;
        if (d !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL fall_flag: got %h required 80000000", d);
        end
        pins[31] = 1'b1;
        step(8);
        pins[31] = 1'b0;
        step(3);
        csr_wr(A_FLAG, 32'h8000_0000);  // commits on the same edge as the new set
        csr_rd(A_FLAG, d, v);
        n_cmp++;
        if (d !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL set_beats_w1c: got %h required 80000000", d);
        end
        csr_wr(A_FLAG, 32'hFFFF_FFFF);
        csr_wr(A_FALL, 32'h0);
    endtask

    task automatic test_filter();
        logic [31:0] d;
        logic v;
        int found;
        csr_wr(A_CTRL, 32'h1);
        csr_wr(A_RISE, 32'h2);
        step(30);
        csr_wr(A_FLAG, 32'hFFFF_FFFF);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            if (en1mhz) found = 1;
            else step(1);
        end
        n_cmp++;
        if (found == 0) begin
            n_err++;
            $display("FAIL en1mhz_seen: got 0 required 1");
        end
        pins[1] = 1'b1;
        step(1);
        pins[1] = 1'b0;
        step(40);
        csr_rd(A_FLAG, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL glitch_flag: got %h required 00000000", d);
        end
        csr_rd(A_IN, d, v);
        n_cmp++;
        if (d !== 32'h1) begin
            n_err++;
            $display("FAIL glitch_in: got %h required 00000001", d);
        end
        pins[1] = 1'b1;
        step(50);
        csr_rd(A_IN, d, v);
        n_cmp++;
        if (d !== 32'h3) begin
            n_err++;
            $display("FAIL filt_in: got %h required 00000003", d);
        end
        csr_rd(A_FLAG, d, v);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL filt_flag: got %h required 00000002", d);
        end
    endtask

    task automatic test_swrst();
        logic [31:0] d;
        logic v;
        logic [31:0] got[4];
        csr_wr(A_IRQ, 32'h2);
        step(2);
        n_cmp++;
        if (xb_int !== 1'b1) begin
            n_err++;
            $display("FAIL swrst_pre_int: got %b required 1", xb_int);
        end
        eic_swrst = 1'b1;
        addr = 3'(A_IRQ);
        wdata = 32'hFFFF;
        wr = 1'b1;
        step(1);
        eic_swrst = 1'b0;
        wr = 1'b0;
        n_cmp++;
        if (xb_int !== 1'b0) begin
            n_err++;
            $display("FAIL swrst_int: got %b required 0", xb_int);
        end
        csr_rd(A_IRQ, got[0], v);
        csr_rd(A_FLAG, got[1], v);
        csr_rd(A_CTRL, got[2], v);
        csr_rd(A_RISE, got[3], v);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== 32'h0) begin
                n_err++;
                $display("FAIL swrst_reg %0d: got %h required 00000000", i, got[i]);
            end
        end
        csr_wr(A_RISE, 32'hFFFF_FFFF);
        csr_wr(A_FALL, 32'hFFFF_FFFF);
        step(10);
        csr_rd(A_FLAG, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL swrst_no_spurious: got %h required 00000000", d);
        end
        csr_wr(A_RISE, 32'h0);
        csr_wr(A_FALL, 32'h0);
    endtask

    task automatic test_rd_wr_same();
        logic [31:0] d;
        logic v;
        csr_wr(A_IRQ, 32'h3);
        addr = 3'(A_IRQ);
        wdata = 32'h5;
        rd = 1'b1;
        wr = 1'b1;
        step(1);
        rd = 1'b0;
        wr = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h3) begin
            n_err++;
            $display("FAIL rdwr_old: got valid=%b data=%h required 1/00000003", rvalid, rdata);
        end
        csr_rd(A_IRQ, d, v);
        n_cmp++;
        if (d !== 32'h5) begin
            n_err++;
            $display("FAIL rdwr_new: got %h required 00000005", d);
        end
        csr_wr(A_NONE, 32'hDEAD_BEEF);
        csr_rd(A_NONE, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL addr7: got %h required 00000000", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic v;
        logic [31:0] re, fe, ie, m_flag, nxt, mask;
        re = $urandom;
        fe = $urandom;
        ie = $urandom;
        csr_wr(A_RISE, re);
        csr_wr(A_FALL, fe);
        csr_wr(A_IRQ, ie);
        csr_wr(A_FLAG, 32'hFFFF_FFFF);
        m_flag = '0;
        for (int it = 0; it < 24; it++) begin
            nxt = pins ^ ($urandom & $urandom);
            m_flag |= (nxt & ~pins & re) | (~nxt & pins & fe);
            pins = nxt;
            step(6);
            n_cmp++;
            if (xb_int !== |(m_flag & ie)) begin
                n_err++;
                $display("FAIL rnd_int it%0d: got %b required %b", it, xb_int, |(m_flag & ie));
            end
            csr_rd(A_FLAG, d, v);
            n_cmp++;
            if (d !== m_flag) begin
                n_err++;
                $display("FAIL rnd_flag it%0d: got %h required %h", it, d, m_flag);
            end
            csr_rd(A_RAW, d, v);
            n_cmp++;
            if (d !== pins) begin
                n_err++;
                $display("FAIL rnd_raw it%0d: got %h required %h", it, d, pins);
            end
            if ($urandom_range(0, 2) == 0) begin
                mask = $urandom;
                csr_wr(A_FLAG, mask);
                m_flag &= ~mask;
            end
            if ($urandom_range(0, 3) == 0) begin
                ie = $urandom;
                csr_wr(A_IRQ, ie);
            end
            if ($urandom_range(0, 3) == 0) begin
                re = $urandom;
                fe = $urandom;
                csr_wr(A_RISE, re);
                csr_wr(A_FALL, fe);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        logic v;
        addr = 3'(A_FLAG);
        rd = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        rd = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b0 || xb_int !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_read: got valid=%b int=%b required 0/0", rvalid, xb_int);
        end
        step(2);
        reset_n = 1'b1;
        step(1);
        csr_rd(A_IRQ, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reset_irq_en: got %h required 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_fall_w1c();
        test_filter();
        test_swrst();
        test_rd_wr_same();
        test_random();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
